// File: rtl/alu.sv
//------------------------------------------------------------------------------
// Module   : alu
// Purpose  : Registered ALU for the CPU datapath. Computes a result and a
//            6-bit status flag word {carry,zero,negative,overflow,equal,greater}
//            with one cycle of latency. Define ALU_ROTATE_EN to enable ROL/ROR.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  input_carry,
    input  logic [3:0]            alu_opcode,
    input  logic                  alu_mode,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic [5:0]            alu_out_flag
);

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_OR  = 4'h1,
        OP_XOR = 4'h2,
        OP_NOT = 4'h3,
        OP_CPR = 4'h4,
        OP_ADD = 4'h8,
        OP_SUB = 4'h9,
        OP_INC = 4'hA,
        OP_DEC = 4'hB,
        OP_SHL = 4'hC,
        OP_SHR = 4'hD,
        OP_ROL = 4'hE,
        OP_ROR = 4'hF
    } enum_alu_opcode_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
        logic equal;
        logic greater;
    } struct_alu_flag_t;

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0]   w_a_ext;
    logic [DATA_WIDTH:0]   w_b_ext;
    logic [DATA_WIDTH:0]   w_cin_ext;
    logic [DATA_WIDTH:0]   w_one_ext;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_carry;
    logic                  w_ovf;
    logic                  w_eq;
    logic                  w_gt;
    logic                  w_legal;
    struct_alu_flag_t      w_flags;

    logic [DATA_WIDTH-1:0] r_out;
    struct_alu_flag_t      r_flags;

    // Zero-extended operands: bit DATA_WIDTH of any sum/difference is carry/borrow.
    assign w_a_ext   = {1'b0, in_a};
    assign w_b_ext   = {1'b0, in_b};
    assign w_cin_ext = {{DATA_WIDTH{1'b0}}, input_carry};
    assign w_one_ext = {{DATA_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_eq    = 1'b0;
        w_gt    = 1'b0;
        w_legal = 1'b1;
        if (!alu_mode) begin
            case (alu_opcode)
                OP_AND: w_res = in_a & in_b;
                OP_OR:  w_res = in_a | in_b;
                OP_XOR: w_res = in_a ^ in_b;
                OP_NOT: w_res = ~in_a;
                OP_CPR: begin
                    w_sum   = w_a_ext - w_b_ext;
                    w_res   = w_sum[MSB:0];
                    w_carry = w_sum[DATA_WIDTH];
                    w_eq    = (in_a == in_b);
                    w_gt    = (in_a > in_b);
                end
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (alu_opcode)
                OP_ADD: begin
                    w_sum   = w_a_ext + w_b_ext + w_cin_ext;
                    w_res   = w_sum[MSB:0];
                    w_carry = w_sum[DATA_WIDTH];
                    w_ovf   = (in_a[MSB] == in_b[MSB]) && (w_res[MSB] != in_a[MSB]);
                end
                OP_SUB: begin
                    w_sum   = w_a_ext - w_b_ext - w_cin_ext;
                    w_res   = w_sum[MSB:0];
                    w_carry = w_sum[DATA_WIDTH];
                    w_ovf   = (in_a[MSB] != in_b[MSB]) && (w_res[MSB] != in_a[MSB]);
                end
                OP_INC: begin
                    w_sum   = w_a_ext + w_one_ext;
                    w_res   = w_sum[MSB:0];
                    w_carry = w_sum[DATA_WIDTH];
                    w_ovf   = !in_a[MSB] && w_res[MSB];
                end
                OP_DEC: begin
                    w_sum   = w_a_ext - w_one_ext;
                    w_res   = w_sum[MSB:0];
                    w_carry = w_sum[DATA_WIDTH];
                    w_ovf   = in_a[MSB] && !w_res[MSB];
                end
                OP_SHL: begin
                    w_res   = {in_a[MSB-1:0], 1'b0};
                    w_carry = in_a[MSB];
                end
                OP_SHR: begin
                    w_res   = {1'b0, in_a[MSB:1]};
                    w_carry = in_a[0];
                end
`ifdef ALU_ROTATE_EN
                OP_ROL: begin
                    w_res   = {in_a[MSB-1:0], in_a[MSB]};
                    w_carry = in_a[MSB];
                end
                OP_ROR: begin
                    w_res   = {in_a[0], in_a[MSB:1]};
                    w_carry = in_a[0];
                end
`endif
                default: w_legal = 1'b0;
            endcase
        end
    end

    // Illegal combinations must report all-zero flags, including zero itself.
    always_comb begin
        w_flags = '0;
        if (w_legal) begin
            w_flags.carry    = w_carry;
            w_flags.zero     = (w_res == '0);
            w_flags.negative = w_res[MSB];
            w_flags.overflow = w_ovf;
            w_flags.equal    = w_eq;
            w_flags.greater  = w_gt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_flags <= '0;
        end else begin
            r_out   <= w_legal ? w_res : '0;
            r_flags <= w_flags;
        end
    end

    assign alu_out      = r_out;
    assign alu_out_flag = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
//------------------------------------------------------------------------------
// Module   : tb_alu
// Purpose  : Directed and random checks of alu against an arithmetic model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        input_carry;
    logic [3:0]  alu_opcode;
    logic        alu_mode;
    logic [15:0] alu_out;
    logic [5:0]  alu_out_flag;

    int checks = 0;
    int errors = 0;

    alu #(.DATA_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_a        (in_a),
        .in_b        (in_b),
        .input_carry (input_carry),
        .alu_opcode  (alu_opcode),
        .alu_mode    (alu_mode),
        .alu_out     (alu_out),
        .alu_out_flag(alu_out_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {carry,zero,negative,overflow,equal,greater,out[15:0]} from integer arithmetic.
    function automatic logic [21:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic [3:0] op,
                                          input logic md);
        int ua, ub, sa, sb, ci, r, sr;
        logic [15:0] o;
        logic cy, ov, eq, gt, legal, arith;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); ci = cin;
        o = 16'h0; cy = 0; ov = 0; eq = 0; gt = 0; legal = 1; arith = 0; r = 0; sr = 0;
        if (!md) begin
            case (op)
                4'h0: o = a & b;
                4'h1: o = a | b;
                4'h2: o = a ^ b;
                4'h3: o = ~a;
                4'h4: begin
                    r = ua - ub; o = 16'(r); cy = (ua < ub); eq = (ua == ub); gt = (ua > ub);
                end
                default: legal = 0;
            endcase
        end else begin
            case (op)
                4'h8: begin r = ua + ub + ci; sr = sa + sb + ci; arith = 1; end
                4'h9: begin r = ua - ub - ci; sr = sa - sb - ci; arith = 1; end
                4'hA: begin r = ua + 1; sr = sa + 1; arith = 1; end
                4'hB: begin r = ua - 1; sr = sa - 1; arith = 1; end
                4'hC: begin o = 16'((ua * 2) % 65536); cy = (ua >= 32768); end
                4'hD: begin o = 16'(ua / 2); cy = (ua % 2 == 1); end
`ifdef ALU_ROTATE_EN
                4'hE: begin o = 16'((ua * 2) % 65536 + ua / 32768); cy = (ua >= 32768); end
                4'hF: begin o = 16'(ua / 2 + (ua % 2) * 32768); cy = (ua % 2 == 1); end
`endif
                default: legal = 0;
            endcase
            if (arith) begin
                o  = 16'(r);
                cy = (r < 0) || (r > 65535);
                ov = (sr > 32767) || (sr < -32768);
            end
        end
        if (!legal) return 22'h0;
        return {cy, (o == 16'h0), o[15], ov, eq, gt, o};
    endfunction

    task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [3:0] op, input logic md,
                        input string tag);
        logic [21:0] exp;
        rst = r; in_a = a; in_b = b; input_carry = cin; alu_opcode = op; alu_mode = md;
        exp = r ? 22'h0 : model(a, b, cin, op, md);
        @(posedge clk);
        #1;
        checks++;
        assert (alu_out === exp[15:0]) else begin
            errors++;
            $error("FAIL %s out: got %h expected %h", tag, alu_out, exp[15:0]);
        end
        checks++;
        assert (alu_out_flag === exp[21:16]) else begin
            errors++;
            $error("FAIL %s flags: got %b expected %b", tag, alu_out_flag, exp[21:16]);
        end
    endtask

    initial begin
        rst = 1'b1; in_a = '0; in_b = '0; input_carry = 1'b0; alu_opcode = 4'h0; alu_mode = 1'b0;

        step(1, 16'd5, 16'd3, 0, 4'h8, 1, "rst_add");
        checks++;
        assert (alu_out === 16'h0 && alu_out_flag === 6'h0) else begin
            errors++;
            $error("FAIL rst_const: got %h/%b expected 0000/000000", alu_out, alu_out_flag);
        end
        step(0, 16'd5, 16'd3, 0, 4'h8, 1, "add_after_rst");
        checks++;
        assert (alu_out === 16'd8) else begin
            errors++;
            $error("FAIL add_8_const: got %h expected 0008", alu_out);
        end

        step(0, 16'd1, 16'd0, 0, 4'h0, 0, "and_10");
        step(0, 16'd1, 16'd1, 0, 4'h0, 0, "and_11");
        step(0, 16'd1, 16'd0, 0, 4'h1, 0, "or_10");
        step(0, 16'h0F0F, 16'h00FF, 0, 4'h2, 0, "xor");
        step(0, 16'h00FF, 16'h0000, 0, 4'h3, 0, "not");
        step(0, 16'd2, 16'd2, 0, 4'h4, 0, "cpr_eq");
        step(0, 16'd20, 16'd10, 0, 4'h4, 0, "cpr_gt");
        step(0, 16'd2, 16'd10, 0, 4'h4, 0, "cpr_lt");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b <= 8; b++) begin
                step(0, 16'(a), 16'(b), 0, 4'h8, 1, "add_sweep");
            end
        end

        step(0, 16'hFFFF, 16'h0001, 0, 4'h8, 1, "add_wrap");
        step(0, 16'h7FFF, 16'h0000, 1, 4'h8, 1, "add_cin_ovf");
        step(0, 16'h8000, 16'h0001, 0, 4'h9, 1, "sub_ovf");
        step(0, 16'h0003, 16'h0003, 1, 4'h9, 1, "sub_borrow");
        step(0, 16'h7FFF, 16'h1234, 1, 4'hA, 1, "inc_ovf");
        step(0, 16'h0000, 16'h1234, 1, 4'hB, 1, "dec_wrap");
        step(0, 16'h8000, 16'h0000, 0, 4'hB, 1, "dec_ovf");
        step(0, 16'd4, 16'd0, 0, 4'hD, 1, "shr_4");
        step(0, 16'd4, 16'd0, 0, 4'hC, 1, "shl_4");
        step(0, 16'h8000, 16'd0, 0, 4'hC, 1, "shl_msb");
        step(0, 16'h0001, 16'd0, 0, 4'hD, 1, "shr_lsb");
        step(0, 16'h8001, 16'd0, 0, 4'hE, 1, "rol");
        step(0, 16'h8001, 16'd0, 0, 4'hF, 1, "ror");
        step(0, 16'hFFFF, 16'hFFFF, 1, 4'h0, 1, "illegal_m1_and");
        step(0, 16'hFFFF, 16'h0001, 1, 4'h8, 0, "illegal_m0_add");
        step(0, 16'h1234, 16'h5678, 0, 4'h6, 0, "illegal_op6");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), 16'($urandom), 16'($urandom),
                 1'($urandom), 4'($urandom), 1'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
